// File: rtl/syscall_output_queue_pkg.sv
// Shared types and constants for the syscall output queue and its word FIFO.
// The optional SYSCALL_OUTPUT_QUEUE_STATS_EN build uses DROP_COUNT_MAX.
package syscall_output_queue_pkg;

    typedef enum logic {IDLE, SEND} state_t;

    localparam int BYTE_BITS = 8;

    localparam logic [15:0] DROP_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/syscall_word_fifo.sv
// Word FIFO between the syscall capture and the byte serializer.
// Pointers carry an extra wrap bit so that full and empty can be told apart.
module syscall_word_fifo #(
    parameter int BITS  = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [BITS-1:0]        pushData,
    input  logic                   pop,
    output logic [BITS-1:0]        headData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rejected
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]     wrPtr_q, wrPtr_d;
    logic [AW:0]     rdPtr_q, rdPtr_d;
    logic [BITS-1:0] mem_q [DEPTH];
    logic            popAccept;
    logic            pushAccept;

    assign full     = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign empty    = (wrPtr_q == rdPtr_q);
    assign count    = wrPtr_q - rdPtr_q;
    assign headData = mem_q[rdPtr_q[AW-1:0]];

    // A pop on the same edge frees the head slot, so a full queue can still take the word.
    assign popAccept  = pop && !empty;
    assign pushAccept = push && (!full || popAccept);
    assign rejected   = push && !pushAccept;

    assign wrPtr_d = pushAccept ? wrPtr_q + 1'b1 : wrPtr_q;
    assign rdPtr_d = popAccept  ? rdPtr_q + 1'b1 : rdPtr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushAccept) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/syscall_output_queue.sv
// Buffers syscall words and serializes them MSB-first onto a valid/ready byte stream.
// Define SYSCALL_OUTPUT_QUEUE_STATS_EN to add the saturating droppedCount output.
module syscall_output_queue
    import syscall_output_queue_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [BITS-1:0]        pushData,
    output logic [7:0]             byteOut,
    output logic                   byteValid,
    input  logic                   byteReady,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   dropped
`ifdef SYSCALL_OUTPUT_QUEUE_STATS_EN
    ,
    output logic [15:0]            droppedCount
`endif
);

    localparam int NBYTES = BITS / BYTE_BITS;
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            pop;
    logic [BITS-1:0] headData;
    logic            rejected;
    logic            dropped_q;

    syscall_word_fifo #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushData),
        .pop      (pop),
        .headData (headData),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .rejected (rejected)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            idx_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            dropped_q <= rejected;
        end
    end

    // On the last accepted byte the next word is reloaded directly, avoiding a bubble.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        byteValid = 1'b0;
        byteOut   = '0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = headData;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                byteValid = 1'b1;
                byteOut   = shift_q[BITS-1 -: BYTE_BITS];
                if (byteReady) begin
                    if (idx_q != LAST_IDX) begin
                        shift_d = shift_q << BYTE_BITS;
                        idx_d   = idx_q + 1'b1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shift_d = headData;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dropped = dropped_q;

`ifdef SYSCALL_OUTPUT_QUEUE_STATS_EN
    logic [15:0] droppedCount_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            droppedCount_q <= '0;
        end else if (rejected && (droppedCount_q != DROP_COUNT_MAX)) begin
            droppedCount_q <= droppedCount_q + 1'b1;
        end
    end

    assign droppedCount = droppedCount_q;
`endif

endmodule

// File: doc/syscall_output_queue.md
Name: syscall_output_queue

Overview:
- Sits directly downstream of the ALU's syscall path. On every syscall it captures the value the ALU exposes, which is the rs/input1 operand.
- Buffers those words in a small FIFO so that a stalled console sink never blocks execution.
- Serializes each word into bytes, MSB first, over a valid/ready byte stream toward the UART/console model.

Parameters:
- BITS, 32, data word width; must be a multiple of 8 and at least 8.
- DEPTH, 8, FIFO depth in words; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  one-cycle strobe per executed syscall; driven from decode where funct == 6'b001100.
- pushData  input  BITS  word to print; the same value the ALU latches into its syscall register.
- byteOut  output  8  current byte on the stream.
- byteValid  output  1  byteOut holds a valid byte.
- byteReady  input  1  sink accepts the byte this cycle.
- full  output  1  FIFO holds DEPTH words.
- empty  output  1  FIFO holds 0 words.
- count  output  $clog2(DEPTH)+1  words currently in the FIFO; excludes the word being serialized.
- dropped  output  1  one-cycle pulse when a push is discarded.

Behaviour:
- Clock and reset: single clock domain, clk. reset is asynchronous and active-high.
- Reset values, effective immediately on assertion: byteOut=0, byteValid=0, full=0, empty=1, count=0, dropped=0. Pointers, shift register and byte index are cleared. FSM goes to IDLE.
- Reset mid-serialization discards the partially sent word and all queued words. There is no resume.
- FIFO pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit. Pointers wrap modulo 2*DEPTH.
  - full = (wr index == rd index) and (wrap bits differ).
  - empty = (pointers equal).
- pop is internal and is asserted only in the cycles described under the FSM.
- Push acceptance: a push is accepted if !full, or if a pop occurs in the same cycle. Write and read then happen on the same edge and count is unchanged.
- Push rejection: when full with no pop, the push is rejected. dropped=1 for the next cycle only. Pointers and contents are unchanged.
- FSM states: IDLE and SEND.
- IDLE:
  - byteValid=0.
  - If !empty, pop. The shift register loads the head word, byte index is set to 0, and the FSM moves to SEND on that edge.
- SEND:
  - byteValid=1 and byteOut = shift[BITS-1 -: 8].
  - byteOut stays stable while byteValid && !byteReady.
  - On byteReady, when byte index < BITS/8-1: shift left by 8 and increment the index.
  - On byteReady with the last byte: if !empty, pop and reload in the same cycle, so the next word's first byte is valid on the next cycle with no bubble. Otherwise go to IDLE.
- Latency: a push accepted at edge N into an empty queue with an idle FSM gives byteValid=1 in the cycle after edge N+1.
- Throughput: one byte per cycle when byteReady is held high. BITS/8 cycles per word.
- Ordering: strict FIFO order; bytes within a word go out MSB first.

Optional Feature:
- Macro: SYSCALL_OUTPUT_QUEUE_STATS_EN.
- When defined, add output port droppedCount, 16 bits. It increments on every rejected push, saturates at 16'hFFFF, and is cleared by reset.
- When undefined, the port and counter do not exist. The dropped pulse is present in both builds.

Decomposition:
- Package syscall_output_queue_pkg holds:
  - the state typedef (enum logic {IDLE, SEND});
  - localparam BYTE_BITS = 8;
  - the saturation constant for droppedCount.
- One sub-module, syscall_word_fifo, parameterized by BITS and DEPTH. It provides push/pop/full/empty/count, with the same-cycle push+pop-when-full rule implemented inside it.
- The top level holds the serializer FSM and the stats counter.

Test Plan:
- Reset, then push pushData=32'hDEADBEEF with byteReady held at 1. Required: bytes DE, AD, BE, EF on 4 consecutive cycles; the first arrives 2 cycles after the push; then byteValid=0 and empty=1.
- Push 32'h11223344 and 32'h55667788 on consecutive cycles with byteReady=1. Required: 8 back-to-back bytes 11 through 88 with no byteValid gap between the two words.
- byteReady=0, then push 9 words 1 through 9 with DEPTH=8. Required:
  - the first word is popped into the shift register, so count=7 after 8 pushes and full stays 0;
  - the 9th push is accepted and gives full=1, count=8;
  - a 10th push gives dropped=1 for exactly one cycle and count stays 8;
  - in the STATS build, droppedCount=1.
- Queue full and the FSM on the last byte with byteReady=1, then push in the same cycle. Required: push accepted, dropped=0, count stays 8.
- Hold byteReady=0 for 5 cycles mid-word. Required: byteOut and byteValid stable throughout; the remaining bytes arrive in order once ready returns.
- Assert reset during the second byte of a word with 3 words queued. Required: byteValid=0 and empty=1 immediately; after release, no stale bytes are emitted.
